// File: rtl/ravenoc_pkg.sv
// Shared NoC types and defaults for the virtual-channel input buffer.
// Build option: define VC_FIXED_PRIO_EN in vc_buffer for fixed-priority VC selection.
package ravenoc_pkg;

  localparam int unsigned FLIT_WIDTH = 34;
  localparam int unsigned N_VIRT_CHN = 3;
  localparam int unsigned VC_DEPTH   = 4;

  // Flit type lives in the top two bits of every flit
  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  // 'type' is a reserved word, so the type field is called flit_type
  typedef struct packed {
    flit_type_t                flit_type;
    logic [FLIT_WIDTH-3:0]     payload;
  } s_flit_t;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } arb_state_t;

  // A packet ends on TAIL or on a single-flit HEAD_TAIL
  function automatic logic is_last(input flit_type_t t);
    return (t == TAIL) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC flit FIFO: registered pointers with a wrap bit, head visible combinationally.
// A write becomes visible at the head one cycle later at the earliest.
module vc_fifo #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(SLOTS);

  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [SLOTS];
  logic             do_write;
  logic             do_read;

  // Full: same slot index, opposite lap
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    do_write = write_i && !full_o;
    do_read  = read_i && !empty_o;
    data_o   = mem_q[rd_ptr_q[PW-1:0]];
  end

  // Storage and pointer update; simultaneous read and write both take effect
  always_ff @(posedge clk) begin
    if (!arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_write) begin
        mem_q[wr_ptr_q[PW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + (PW+1)'(1);
      end
      if (do_read) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/vc_buffer.sv
// Multi-VC input buffer: one FIFO per VC, packet-locked arbiter onto a single output link.
// Build option: VC_FIXED_PRIO_EN selects lowest-index-first instead of round-robin.
module vc_buffer #(
  parameter int unsigned N_VIRT_CHN = ravenoc_pkg::N_VIRT_CHN,
  parameter int unsigned VC_DEPTH   = ravenoc_pkg::VC_DEPTH,
  parameter int unsigned FLIT_WIDTH = ravenoc_pkg::FLIT_WIDTH,
  localparam int unsigned VC_W      = $clog2(N_VIRT_CHN)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [VC_W-1:0]       in_vc_id,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [VC_W-1:0]       out_vc_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_VIRT_CHN-1:0] vc_full,
  output logic [N_VIRT_CHN-1:0] vc_empty
);

  import ravenoc_pkg::*;

  logic [N_VIRT_CHN-1:0] wr_en;
  logic [N_VIRT_CHN-1:0] rd_en;
  logic [FLIT_WIDTH-1:0] head [N_VIRT_CHN];

  arb_state_t            state_q, state_d;
  logic [VC_W-1:0]       cur_vc_q, cur_vc_d;
  logic                  found;
  int                    idx;
`ifndef VC_FIXED_PRIO_EN
  logic [VC_W-1:0]       rr_ptr_q, rr_ptr_d;
`endif

  // Input side: ids beyond the last VC never match, so they look full
  always_comb begin
    in_ready = 1'b0;
    wr_en    = '0;
    for (int g = 0; g < int'(N_VIRT_CHN); g++) begin
      if (in_vc_id == VC_W'(g)) begin
        in_ready = !vc_full[g];
        wr_en[g] = in_valid && !vc_full[g];
      end
    end
  end

  for (genvar g = 0; g < N_VIRT_CHN; g++) begin : g_vc
    vc_fifo #(
      .SLOTS(VC_DEPTH),
      .WIDTH(FLIT_WIDTH)
    ) u_fifo (
      .clk    (clk),
      .arst   (arst),
      .write_i(wr_en[g]),
      .read_i (rd_en[g]),
      .data_i (in_flit),
      .data_o (head[g]),
      .full_o (vc_full[g]),
      .empty_o(vc_empty[g])
    );
  end

  // Arbiter: pick a VC in IDLE, then stay on it until a TAIL/HEAD_TAIL is popped
  always_comb begin
    state_d   = state_q;
    cur_vc_d  = cur_vc_q;
`ifndef VC_FIXED_PRIO_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    out_valid = 1'b0;
    out_flit  = '0;
    out_vc_id = cur_vc_q;
    rd_en     = '0;
    found     = 1'b0;
    idx       = 0;
    unique case (state_q)
      StIdle: begin
        for (int i = 0; i < int'(N_VIRT_CHN); i++) begin
`ifdef VC_FIXED_PRIO_EN
          idx = i;
`else
          idx = (int'(rr_ptr_q) + i) % int'(N_VIRT_CHN);
`endif
          if (!found && !vc_empty[idx]) begin
            found    = 1'b1;
            cur_vc_d = VC_W'(idx);
            state_d  = StActive;
          end
        end
      end
      StActive: begin
        // An empty locked VC mid-packet just stalls; no other VC is considered
        out_valid = !vc_empty[cur_vc_q];
        out_flit  = head[cur_vc_q];
        if (out_valid && out_ready) begin
          rd_en[cur_vc_q] = 1'b1;
          if (is_last(flit_type_t'(out_flit[FLIT_WIDTH-1 -: 2]))) begin
            state_d = StIdle;
`ifndef VC_FIXED_PRIO_EN
            rr_ptr_d = (cur_vc_q == VC_W'(N_VIRT_CHN - 1)) ? '0 : cur_vc_q + VC_W'(1);
`endif
          end
        end
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (!arst) begin
      state_q  <= StIdle;
      cur_vc_q <= '0;
`ifndef VC_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_vc_q <= cur_vc_d;
`ifndef VC_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: doc/vc_buffer.md
Name: vc_buffer

Overview:
- Parametrised successor to the single-channel VC controller: N virtual channels, each with its own flit FIFO, sharing one input link and one output link toward the router control.
- Accepts tagged flits per VC with per-VC backpressure.
- Arbitrates round-robin among VCs, holding the output on one VC for a whole packet (HEAD to TAIL) so packets never interleave on the output.

Parameters:
- N_VIRT_CHN, 3, number of virtual channels (>=2).
- VC_DEPTH, 4, flit slots per VC FIFO (power of 2, >=2).
- FLIT_WIDTH, 34, flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] carry the flit type.
- VC_W, $clog2(N_VIRT_CHN), VC id width (derived localparam).

Ports:
- clk  in  1  clock
- arst  in  1  reset, synchronous, active-low (asserted when 0, sampled on rising clk)
- in_vc_id  in  VC_W  destination VC of the incoming flit
- in_flit  in  FLIT_WIDTH  incoming flit
- in_valid  in  1  incoming flit valid
- in_ready  out  1  = !vc_full[in_vc_id]; combinational
- out_flit  out  FLIT_WIDTH  head flit of the granted VC
- out_vc_id  out  VC_W  granted VC
- out_valid  out  1  output flit valid
- out_ready  in  1  downstream accepts
- vc_full  out  N_VIRT_CHN  per-VC full flags
- vc_empty  out  N_VIRT_CHN  per-VC empty flags

Behaviour:
- Flit type encoding: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL.
- Write: when in_valid && in_ready, in_flit is pushed into FIFO[in_vc_id].
  - in_valid with in_ready=0 is a stall; the sender holds the flit.
  - in_vc_id >= N_VIRT_CHN is a full VC: in_ready=0, never written.
- FIFO: registered pointers, depth VC_DEPTH, pointer width $clog2(VC_DEPTH)+1 with wrap bit.
  - Full when pointers differ only in the MSB.
  - A read and a write on the same VC in the same cycle are both performed; occupancy is unchanged.
  - No write-through: a flit written in cycle N is readable in cycle N+1 at the earliest.
- Arbiter FSM, states IDLE and ACTIVE; registers cur_vc and rr_ptr.
  - IDLE: out_valid=0. If any VC is non-empty, select the first non-empty VC scanning from rr_ptr upward (mod N), load cur_vc, go to ACTIVE. Otherwise stay in IDLE.
  - ACTIVE: out_valid = !vc_empty[cur_vc]; out_flit = head of FIFO[cur_vc]; out_vc_id = cur_vc.
  - Handshake (out_valid && out_ready) pops FIFO[cur_vc].
  - If the popped flit is TAIL or HEAD_TAIL: go to IDLE and set rr_ptr = (cur_vc+1) mod N. Otherwise stay in ACTIVE on the same VC.
  - Locked VC empty mid-packet: out_valid=0, stay in ACTIVE, no switch to another VC.
- Latency: empty VC with the arbiter in IDLE gives a minimum of 2 cycles from write to out_valid. Within a packet, 1 flit per cycle.
- Stability: while out_valid && !out_ready, out_flit and out_vc_id hold constant; the FIFO head cannot change without a pop.
- No protocol checking. A BODY flit arriving as a packet start is forwarded, and the arbiter stays locked until a TAIL or HEAD_TAIL.
- Reset values:
  - all FIFOs empty: vc_empty all 1s, vc_full all 0s
  - state IDLE, cur_vc=0, rr_ptr=0
  - out_valid=0, out_flit=0, out_vc_id=0
- Reset mid-packet discards all buffered flits and releases the lock.

Optional Feature:
- Macro VC_FIXED_PRIO_EN.
- Defined: IDLE selection is fixed priority, lowest non-empty VC index wins; rr_ptr is not implemented.
- Undefined (default): round-robin as described above.
- Packet locking is identical in both modes.

Decomposition:
- ravenoc_pkg gains:
  - flit_type_t enum (HEAD, BODY, TAIL, HEAD_TAIL)
  - localparams FLIT_WIDTH, N_VIRT_CHN, VC_DEPTH
  - s_flit_t packed struct {flit_type_t type; logic [FLIT_WIDTH-3:0] payload}
- One sub-module: vc_fifo (SLOTS, WIDTH; ports clk, arst, write_i, read_i, data_i, data_o, full_o, empty_o), instantiated N_VIRT_CHN times in a generate loop.
- The arbiter stays in vc_buffer.

Test Plan:
- Reset: drive arst=0 for 3 cycles with in_valid=1 -> out_valid=0, vc_empty=3'b111, vc_full=0, and no flit accepted.
- Single flit: HEAD_TAIL payload 0x1234 on VC1 at cycle 0, out_ready=1 -> out_valid=1 at cycle 2, out_vc_id=1, out_flit=that flit, popped; then vc_empty[1]=1.
- Full: 4 writes to VC0, out_ready=0 -> vc_full[0]=1 and in_ready=0 for in_vc_id=0; a write to VC2 is still accepted; one pop deasserts vc_full[0] the next cycle.
- Packet lock: load VC0 with HEAD, BODY, TAIL and VC1 with HEAD_TAIL, out_ready=1 -> output order VC0 H, B, T contiguous, then VC1 HT.
- Packet lock, gap: VC0 TAIL is delayed 3 cycles -> out_valid=0 for those cycles, VC1 is not served.
- Fairness: VC0/1/2 each preloaded with two HEAD_TAIL flits -> output VC order 0,1,2,0,1,2. With VC_FIXED_PRIO_EN defined -> order 0,0,1,1,2,2.
- Backpressure and reset: out_ready=0 for 5 cycles mid-packet -> out_flit and out_vc_id stable. Then arst=0 for 1 cycle -> next cycle all VCs empty, out_valid=0, state IDLE.
